// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ==== fetch_ctrl_pkg : shared widths, reset PC, FSM encoding, counter helper ====
// ==== Rev 1.0                                                                ====
package fetch_ctrl_pkg;

  localparam int          DEF_ADDR_W   = 64;
  localparam int          DEF_INST_W   = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
  localparam int          DEF_PC_STEP  = 4;
  localparam int          PERF_W       = 32;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_REQ  = 3'd1,
    FS_WAIT = 3'd2,
    FS_HOLD = 3'd3,
    FS_DROP = 3'd4
  } fetch_state_e;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_dff.sv
`default_nettype none
// ==== fetch_ctrl_dff : write-enabled register, synchronous active-low clear ====
// ==== Rev 1.0                                                              ====
module fetch_ctrl_dff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (wen) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ==== fetch_ctrl : PC owner + one-outstanding imem fetch FSM feeding the F->D slot ====
// ==== Rev 1.0 ; optional perf counters under FETCH_PERF_EN                        ====
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                PC_STEP  = DEF_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              dec_ready,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              if_valid_q, if_valid_d;
  logic              slot_load;
  logic              deliver;
  logic [ADDR_W+INST_W-1:0] slot_q;

  assign deliver = if_valid_q && dec_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q && !dec_ready;
    slot_load  = 1'b0;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      unique case (state_q)
        FS_REQ:  state_d = imem_req_ready  ? FS_DROP : FS_REQ;
        FS_WAIT: state_d = imem_resp_valid ? FS_REQ  : FS_DROP;
        // The orphan response arriving with the redirect is the one DROP awaits
        FS_DROP: state_d = imem_resp_valid ? FS_REQ  : FS_DROP;
        default: state_d = FS_REQ;
      endcase
    end else begin
      unique case (state_q)
        FS_IDLE: state_d = FS_REQ;
        FS_REQ: begin
          if (imem_req_ready) begin
            state_d  = FS_WAIT;
            pc_d     = pc_q + ADDR_W'(PC_STEP);
            req_pc_d = pc_q;
          end
        end
        FS_WAIT: begin
          if (imem_resp_valid) begin
            state_d    = FS_HOLD;
            slot_load  = 1'b1;
            if_valid_d = 1'b1;
          end
        end
        FS_HOLD: if (!if_valid_q || dec_ready) state_d = FS_REQ;
        FS_DROP: if (imem_resp_valid) state_d = FS_REQ;
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  fetch_ctrl_dff #(
    .WIDTH(ADDR_W + INST_W)
  ) u_slot (
    .clk(clk),
    .rst(rst),
    .wen(slot_load),
    .d  ({req_pc_q, imem_resp_inst}),
    .q  (slot_q)
  );

  assign imem_req_valid = (state_q == FS_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = slot_q[ADDR_W+INST_W-1:INST_W];
  assign if_inst        = slot_q[INST_W-1:0];

`ifdef FETCH_PERF_EN
  logic [PERF_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (deliver)                  fetch_cnt_d = sat_inc(fetch_cnt_q);
    if (if_valid_q && !dec_ready) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
`default_nettype wire
